// File: rtl/bsg_fifo_reorder_alloc_issue_pkg.sv
// Shared types for the reorder-FIFO allocate/issue front-end.
// Holds the issue FSM state encoding and a width helper.
// Imported by the top module and nothing else.
package bsg_fifo_reorder_alloc_issue_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } state_e;

   // Bits needed to hold the value x itself (0..x inclusive).
   function automatic int bsg_width(input int x);
      return $clog2(x + 1);
   endfunction

endpackage

// File: rtl/bsg_fifo_reorder_alloc_issue_counter.sv
// Beat index counter: synchronous clear on request load, increment on a non-last beat.
// Latency: count_o reflects clear/up one cycle after they are asserted.
// Backpressure: none of its own; the caller only asserts up_i on a beat handshake.
// Ports: clk_i/reset_i (async active-high), clear_i, up_i, count_o.
module bsg_fifo_reorder_alloc_issue_counter #(
   parameter int width_p = 2
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               clear_i,
   input  logic               up_i,
   output logic [width_p-1:0] count_o
);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         count_o <= '0;
      end else if (clear_i) begin
         // Clear wins: a reload never coincides with a non-last beat anyway.
         count_o <= '0;
      end else if (up_i) begin
         count_o <= count_o + width_p'(1);
      end
   end

endmodule

// File: rtl/bsg_fifo_reorder_alloc_issue.sv
// Reserves req_beats_i contiguous reorder slots per request, then issues one ID-tagged beat per cycle.
// Latency: request accepted at cycle t -> beat 0 valid at t+1; 1 beat/cycle with no bubble between requests.
// Backpressure: beat_ready_and_i stalls the beat stream (payload held); requests wait until the last beat
//   drains and enough free slots exist.
// Ports: req_* (request in), alloc_* (reorder FIFO slot allocation), beat_* (tagged beats out), busy_o.
module bsg_fifo_reorder_alloc_issue
   import bsg_fifo_reorder_alloc_issue_pkg::*;
#(
   parameter int width_p     = 32,
   parameter int els_p       = 16,
   parameter int beats_max_p = 4,
   localparam int beats_w    = $clog2(beats_max_p + 1),
   localparam int cnt_w      = $clog2(els_p + 1),
   localparam int id_w       = $clog2(els_p),
   localparam int idx_w      = (beats_max_p > 1) ? $clog2(beats_max_p) : 1
) (
   input  logic               clk_i,
   input  logic               reset_i,

   input  logic               req_v_i,
   input  logic [beats_w-1:0] req_beats_i,
   input  logic [width_p-1:0] req_data_i,
   output logic               req_ready_and_o,

   input  logic [cnt_w-1:0]   alloc_v_count_i,
   input  logic [id_w-1:0]    alloc_id_i,
   output logic [cnt_w-1:0]   alloc_yumi_variable_o,

   output logic               beat_v_o,
   output logic [width_p-1:0] beat_data_o,
   output logic [id_w-1:0]    beat_id_o,
   output logic [idx_w-1:0]   beat_idx_o,
   output logic               beat_last_o,
   input  logic               beat_ready_and_i,

   output logic               busy_o
);

   state_e               state_q;
   logic [id_w-1:0]      base_q;
   logic [width_p-1:0]   data_q;
   logic [beats_w-1:0]   cnt_q;
   logic [idx_w-1:0]     idx;

   logic legal, fits, accept, beat_hs;

   // Illegal beat counts are never accepted, so they can never reserve slots.
   assign legal = (req_beats_i != '0) && (req_beats_i <= beats_w'(beats_max_p));
   assign fits  = legal && (alloc_v_count_i >= cnt_w'(req_beats_i));

   assign beat_v_o    = (state_q == ISSUE);
   assign beat_last_o = beat_v_o && (beats_w'(idx) == (cnt_q - beats_w'(1)));
   assign beat_hs     = beat_v_o && beat_ready_and_i;

   // In ISSUE a new request may only load as the last beat leaves, giving back-to-back issue.
   assign req_ready_and_o = fits && (!beat_v_o || (beat_last_o && beat_ready_and_i));
   assign accept          = req_v_i && req_ready_and_o;

   assign alloc_yumi_variable_o = accept ? cnt_w'(req_beats_i) : '0;

   // Slot ID wraps naturally in id_w bits because els_p is a power of two.
   assign beat_id_o   = base_q + id_w'(idx);
   assign beat_idx_o  = idx;
   assign beat_data_o = data_q;
   assign busy_o      = (state_q != IDLE);

   bsg_fifo_reorder_alloc_issue_counter #(
      .width_p (idx_w)
   ) beat_ctr (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (accept),
      .up_i    (beat_hs && !beat_last_o),
      .count_o (idx)
   );

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         base_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
      end else begin
         if (accept) begin
            state_q <= ISSUE;
            base_q  <= alloc_id_i;
            data_q  <= req_data_i;
            cnt_q   <= req_beats_i;
         end else if (beat_hs && beat_last_o) begin
            state_q <= IDLE;
         end
      end
   end

   a_legal_beats : assert property (@(posedge clk_i) disable iff (reset_i) req_v_i |-> legal);

endmodule

// File: tb/tb_bsg_fifo_reorder_alloc_issue.sv
module tb_bsg_fifo_reorder_alloc_issue;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        req_v_i;
   logic [2:0]  req_beats_i;
   logic [31:0] req_data_i;
   logic        req_ready_and_o;
   logic [4:0]  alloc_v_count_i;
   logic [3:0]  alloc_id_i;
   logic [4:0]  alloc_yumi_variable_o;
   logic        beat_v_o;
   logic [31:0] beat_data_o;
   logic [3:0]  beat_id_o;
   logic [1:0]  beat_idx_o;
   logic        beat_last_o;
   logic        beat_ready_and_i;
   logic        busy_o;

   always #5 clk_i = ~clk_i;

   bsg_fifo_reorder_alloc_issue #(
      .width_p(32), .els_p(16), .beats_max_p(4)
   ) dut (
      .clk_i                 (clk_i),
      .reset_i               (reset_i),
      .req_v_i               (req_v_i),
      .req_beats_i           (req_beats_i),
      .req_data_i            (req_data_i),
      .req_ready_and_o       (req_ready_and_o),
      .alloc_v_count_i       (alloc_v_count_i),
      .alloc_id_i            (alloc_id_i),
      .alloc_yumi_variable_o (alloc_yumi_variable_o),
      .beat_v_o              (beat_v_o),
      .beat_data_o           (beat_data_o),
      .beat_id_o             (beat_id_o),
      .beat_idx_o            (beat_idx_o),
      .beat_last_o           (beat_last_o),
      .beat_ready_and_i      (beat_ready_and_i),
      .busy_o                (busy_o)
   );

   typedef struct {
      int          id;
      int          idx;
      logic [31:0] data;
      bit          last;
   } beat_t;

   beat_t exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Monitor / scoreboard: outstanding beats are a queue; the DUT is idle exactly when it is empty.
   always @(negedge clk_i) begin
      int    sz;
      bit    exp_rdy;
      beat_t e;
      beat_t nb;
      if (!reset_i) begin
         sz = exp_q.size();
         chk("beat_v", beat_v_o, sz != 0);
         chk("busy", busy_o, sz != 0);
         if (sz != 0) begin
            e = exp_q[0];
            chk("beat_id", beat_id_o, e.id);
            chk("beat_idx", beat_idx_o, e.idx);
            chk("beat_data", beat_data_o, e.data);
            chk("beat_last", beat_last_o, e.last);
            if (beat_ready_and_i) void'(exp_q.pop_front());
         end
         exp_rdy = (int'(alloc_v_count_i) >= int'(req_beats_i)) &&
                   (sz == 0 || (sz == 1 && beat_ready_and_i));
         chk("req_ready", req_ready_and_o, exp_rdy);
         if (req_v_i && req_ready_and_o) begin
            chk("alloc_yumi", alloc_yumi_variable_o, req_beats_i);
            for (int k = 0; k < int'(req_beats_i); k++) begin
               nb.id   = (int'(alloc_id_i) + k) % 16;
               nb.idx  = k;
               nb.data = req_data_i;
               nb.last = (k == int'(req_beats_i) - 1);
               exp_q.push_back(nb);
            end
         end else begin
            chk("alloc_yumi_idle", alloc_yumi_variable_o, 0);
         end
      end
   end

   task automatic drive(input bit v, input int beats, input logic [31:0] data,
                        input int free, input int id, input bit brdy);
      req_v_i          = v;
      req_beats_i      = 3'(beats);
      req_data_i       = data;
      alloc_v_count_i  = 5'(free);
      alloc_id_i       = 4'(id);
      beat_ready_and_i = brdy;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      drive(0, 1, 32'h0, 16, 0, 1);
      repeat (n) tick();
   endtask

   initial begin
      reset_i = 1'b1;
      drive(0, 1, 32'h0, 0, 0, 1);
      #1;
      chk("rst_beat_v", beat_v_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_yumi", alloc_yumi_variable_o, 0);
      chk("rst_ready", req_ready_and_o, 0);
      chk("rst_beat_id", beat_id_o, 0);
      chk("rst_beat_data", beat_data_o, 0);
      repeat (2) tick();
      reset_i = 1'b0;
      tick();

      // 1: basic 3-beat request
      drive(1, 3, 32'hA5, 16, 5, 1);
      tick();
      idle(4);

      // 2: ID wrap
      drive(1, 4, 32'h1234, 16, 14, 1);
      tick();
      idle(5);

      // 3: request held until free slots suffice
      drive(1, 3, 32'hBEEF, 2, 7, 1);
      repeat (3) tick();
      alloc_v_count_i = 5'd3;
      tick();
      idle(4);

      // 4: 1-beat requests back to back
      drive(1, 1, 32'h11, 16, 2, 1);
      tick();
      drive(1, 1, 32'h22, 16, 3, 1);
      tick();
      drive(1, 1, 32'h33, 16, 4, 1);
      tick();
      idle(3);

      // 5: stall mid-request with a new request pending
      drive(1, 4, 32'hCAFE, 16, 3, 1);
      tick();
      tick();
      drive(1, 2, 32'hD00D, 16, 10, 0);
      repeat (4) tick();
      beat_ready_and_i = 1'b1;
      repeat (3) tick();
      idle(4);

      // 6: asynchronous reset mid-ISSUE
      drive(1, 4, 32'h7777, 16, 0, 1);
      tick();
      drive(0, 1, 32'h0, 16, 0, 1);
      tick();
      #2;
      reset_i = 1'b1;
      exp_q.delete();
      #1;
      chk("mid_rst_beat_v", beat_v_o, 0);
      chk("mid_rst_busy", busy_o, 0);
      tick();
      reset_i = 1'b0;
      drive(1, 2, 32'h9999, 16, 9, 1);
      tick();
      idle(4);

      // Random traffic
      repeat (3000) begin
         drive($urandom_range(0, 9) < 7, $urandom_range(1, 4), $urandom,
               $urandom_range(0, 16), $urandom_range(0, 15), $urandom_range(0, 9) < 8);
         tick();
      end

      idle(10);
      chk("drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
